// File: rtl/fetch_pkg.sv
// fetch_pkg: shared image geometry, buffer depth and FSM encoding for the fetch engine
package fetch_pkg;
    localparam int MAX_ROW   = 540;
    localparam int MAX_COL   = 540;
    localparam int IMG_SIZE  = MAX_ROW * MAX_COL;
    localparam int BUF_DEPTH = 2048;
    localparam int WIN_ROWS  = 3;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;
endpackage

// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: steps the window top row and its BRAM base address, wrapping per frame
//   clk, rst_n : clock, async active-low reset
//   advance    : move to the next window (after a completed fetch)
//   abort      : suppress any step in this cycle
//   top_row    : top row of the current window
//   win_base   : top_row*MAX_COL, kept by accumulation
module fetch_addr_gen
    import fetch_pkg::*;
#(
    parameter int MAX_ROW = fetch_pkg::MAX_ROW,
    parameter int MAX_COL = fetch_pkg::MAX_COL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        abort,
    output logic [9:0]  top_row,
    output logic [19:0] win_base
);
    logic wrap;
    assign wrap = top_row == 10'(MAX_ROW - WIN_ROWS);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            top_row  <= '0;
            win_base <= '0;
        end else if (advance && !abort) begin
            top_row  <= wrap ? '0 : top_row + 10'd1;
            win_base <= wrap ? '0 : win_base + 20'(MAX_COL);
        end
endmodule

// File: rtl/mem_fetch_engine.sv
// mem_fetch_engine: copies a window of pixels from BRAM into a line buffer, one window row step per fetch
//   fetch_run_i/cnt_len_i : request level and length from the controller
//   fetch_done_o          : one-cycle completion pulse; cnt_img_row_o = top row of that window
//   bram_en_o/bram_addr_o/bram_rdata_i : BRAM read port (data one cycle after enable)
//   buf_wr_en_o/buf_wr_addr_o/buf_wdata_o : line-buffer write port
//   state_o               : FSM state for debug
module mem_fetch_engine
    import fetch_pkg::*;
#(
    parameter int MAX_ROW   = fetch_pkg::MAX_ROW,
    parameter int MAX_COL   = fetch_pkg::MAX_COL,
    parameter int BUF_DEPTH = fetch_pkg::BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_run_i,
    input  logic [19:0] cnt_len_i,
    output logic        fetch_done_o,
    output logic [9:0]  cnt_img_row_o,
    output logic        bram_en_o,
    output logic [19:0] bram_addr_o,
    input  logic [7:0]  bram_rdata_i,
    output logic        buf_wr_en_o,
    output logic [10:0] buf_wr_addr_o,
    output logic [7:0]  buf_wdata_o,
    output logic [2:0]  state_o
);
    localparam int LW      = $clog2(BUF_DEPTH + 1);
    localparam int IMG_END = MAX_ROW * MAX_COL;
    state_t        state;
    logic [LW-1:0] len, len_in, idx, wr_idx;
    logic [20:0]   iss_addr;
    logic          in_img, rd_hit, advance, abort;
    logic [9:0]    top_row;
    logic [19:0]   win_base;
    assign len_in   = (cnt_len_i > 20'(BUF_DEPTH)) ? LW'(BUF_DEPTH) : LW'(cnt_len_i);
    assign iss_addr = 21'(win_base) + 21'(idx);
    assign in_img   = iss_addr < 21'(IMG_END);
    assign wr_idx   = idx - 1'b1;
    // Zero-length fetches complete from IDLE; normal ones on the first DONE cycle.
    assign advance  = (state == S_DONE && !fetch_done_o) || (state == S_IDLE && fetch_run_i && len_in == '0);
    assign abort    = (state == S_READ || state == S_DRAIN) && !fetch_run_i;
    // Reads past the image are never issued, so their buffer slot is filled with zero.
    assign buf_wdata_o = rd_hit ? bram_rdata_i : 8'h00;
    assign state_o  = state;
    fetch_addr_gen #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (advance),
        .abort   (abort),
        .top_row (top_row),
        .win_base(win_base)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= S_IDLE;
            len           <= '0;
            idx           <= '0;
            rd_hit        <= 1'b0;
            fetch_done_o  <= 1'b0;
            cnt_img_row_o <= '0;
            bram_en_o     <= 1'b0;
            bram_addr_o   <= '0;
            buf_wr_en_o   <= 1'b0;
            buf_wr_addr_o <= '0;
        end else begin
            fetch_done_o <= 1'b0;
            bram_en_o    <= 1'b0;
            buf_wr_en_o  <= 1'b0;
            rd_hit       <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (fetch_run_i) begin
                        len <= len_in;
                        if (len_in == '0) begin
                            fetch_done_o  <= 1'b1;
                            cnt_img_row_o <= top_row;
                            state         <= S_DONE;
                        end else begin
                            bram_en_o   <= in_img;
                            bram_addr_o <= iss_addr[19:0];
                            idx         <= idx + 1'b1;
                            state       <= (len_in == LW'(1)) ? S_DRAIN : S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (!fetch_run_i) state <= S_IDLE;
                    else begin
                        buf_wr_en_o   <= 1'b1;
                        buf_wr_addr_o <= 11'(wr_idx);
                        rd_hit        <= bram_en_o;
                        bram_en_o     <= in_img;
                        bram_addr_o   <= iss_addr[19:0];
                        idx           <= idx + 1'b1;
                        if (idx == len - 1'b1) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!fetch_run_i) state <= S_IDLE;
                    else begin
                        buf_wr_en_o   <= 1'b1;
                        buf_wr_addr_o <= 11'(wr_idx);
                        rd_hit        <= bram_en_o;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A pulse already raised from IDLE (zero length) is not repeated.
                    fetch_done_o <= !fetch_done_o;
                    if (!fetch_done_o) cnt_img_row_o <= top_row;
                    state <= S_WAIT;
                end
                S_WAIT: if (!fetch_run_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_mem_fetch_engine.sv
// tb_mem_fetch_engine: scoreboard bench for mem_fetch_engine
module tb_mem_fetch_engine;
    localparam int ROWS = 540;
    localparam int COLS = 540;
    localparam int IMG  = ROWS * COLS;
    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_run_i = 1'b0;
    logic [19:0] cnt_len_i = '0;
    logic        fetch_done_o;
    logic [9:0]  cnt_img_row_o;
    logic        bram_en_o;
    logic [19:0] bram_addr_o;
    logic [7:0]  bram_rdata_i = '0;
    logic        buf_wr_en_o;
    logic [10:0] buf_wr_addr_o;
    logic [7:0]  buf_wdata_o;
    logic [2:0]  state_o;
    int          checks = 0;
    int          errors = 0;
    int          exp_row = 0;
    logic [19:0] rd_q[$];
    wr_t         wr_q[$];
    logic [9:0]  dn_q[$];
    wr_t         w;

    mem_fetch_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_run_i  (fetch_run_i),
        .cnt_len_i    (cnt_len_i),
        .fetch_done_o (fetch_done_o),
        .cnt_img_row_o(cnt_img_row_o),
        .bram_en_o    (bram_en_o),
        .bram_addr_o  (bram_addr_o),
        .bram_rdata_i (bram_rdata_i),
        .buf_wr_en_o  (buf_wr_en_o),
        .buf_wr_addr_o(buf_wr_addr_o),
        .buf_wdata_o  (buf_wdata_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bram_en_o) bram_rdata_i <= bram_addr_o[7:0];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (bram_en_o) begin
            if (rd_q.size() == 0) chk("rd_unexpected", int'(bram_addr_o), -1);
            else chk("rd_addr", int'(bram_addr_o), int'(rd_q.pop_front()));
        end
        if (buf_wr_en_o) begin
            if (wr_q.size() == 0) chk("wr_unexpected", int'(buf_wr_addr_o), -1);
            else begin
                w = wr_q.pop_front();
                chk("wr_addr", int'(buf_wr_addr_o), int'(w.a));
                chk("wr_data", int'(buf_wdata_o), int'(w.d));
            end
        end
        if (fetch_done_o) begin
            if (dn_q.size() == 0) chk("done_unexpected", int'(cnt_img_row_o), -1);
            else chk("done_row", int'(cnt_img_row_o), int'(dn_q.pop_front()));
        end
    end

    task automatic push_exp(input int row, input int n_rd, input int n_wr);
        int base;
        base = row * COLS;
        for (int i = 0; i < n_rd; i++) if (base + i < IMG) rd_q.push_back(20'(base + i));
        for (int i = 0; i < n_wr; i++)
            wr_q.push_back('{a: 11'(i), d: (base + i < IMG) ? 8'(base + i) : 8'h00});
    endtask

    task automatic run_fetch(input int len, input int hold);
        int eff, n;
        eff = len > 2048 ? 2048 : len;
        push_exp(exp_row, eff, eff);
        dn_q.push_back(10'(exp_row));
        @(negedge clk);
        fetch_run_i = 1'b1;
        cnt_len_i   = 20'(len);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) cnt_len_i = 20'd3;
        end while (!fetch_done_o && n < 3000);
        chk("done_cycle", n, eff == 0 ? 1 : eff + 2);
        exp_row = exp_row == ROWS - 3 ? 0 : exp_row + 1;
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("wait_state", int'(state_o), 4);
        @(negedge clk);
        fetch_run_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_abort(input int len, input int cyc);
        int n;
        push_exp(exp_row, cyc, cyc - 1);
        @(negedge clk);
        fetch_run_i = 1'b1;
        cnt_len_i   = 20'(len);
        n = 0;
        while (n < cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        fetch_run_i = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_state", int'(state_o), 0);
        chk("abort_bram_en", int'(bram_en_o), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(fetch_done_o), 0);
        chk("rst_bram_en", int'(bram_en_o), 0);
        chk("rst_wr_en", int'(buf_wr_en_o), 0);
        chk("rst_bram_addr", int'(bram_addr_o), 0);
        chk("rst_wr_addr", int'(buf_wr_addr_o), 0);
        chk("rst_wdata", int'(buf_wdata_o), 0);
        chk("rst_row", int'(cnt_img_row_o), 0);
        chk("rst_state", int'(state_o), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_fetch(1620, 0);
        run_fetch(1620, 10);
        run_abort(1620, 701);
        run_fetch(1620, 0);
        run_fetch(0, 0);
        while (exp_row < ROWS - 3) run_fetch(1, 0);
        run_fetch(5000, 0);
        run_fetch(1620, 0);
        push_exp(exp_row, 10, 9);
        @(negedge clk);
        fetch_run_i = 1'b1;
        cnt_len_i   = 20'd1620;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bram_en", int'(bram_en_o), 0);
        chk("midrst_wr_en", int'(buf_wr_en_o), 0);
        chk("midrst_done", int'(fetch_done_o), 0);
        chk("midrst_wdata", int'(buf_wdata_o), 0);
        chk("midrst_state", int'(state_o), 0);
        fetch_run_i = 1'b0;
        exp_row = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_fetch(3, 0);
        repeat (3) @(negedge clk);
        chk("rd_q_left", rd_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);
        chk("dn_q_left", dn_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_fetch_engine.md
MEM_FETCH_ENGINE -- requirements
Module: mem_fetch_engine

Interface
REQ-001 SHALL have parameter MAX_ROW, default 540: image rows.
REQ-002 SHALL have parameter MAX_COL, default 540: image columns (pixels per row).
REQ-003 SHALL have parameter BUF_DEPTH, default 2048: line-buffer entries.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port fetch_run_i  input  1  fetch request level from controller, held high for the whole fetch.
REQ-008 SHALL have port cnt_len_i  input  20  pixels to transfer, sampled at fetch start.
REQ-009 SHALL have port fetch_done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port cnt_img_row_o  output  10  top row index of the last completed window.
REQ-011 SHALL have port bram_en_o  output  1  BRAM read enable.
REQ-012 SHALL have port bram_addr_o  output  20  BRAM pixel address.
REQ-013 SHALL have port bram_rdata_i  input  8  BRAM read data, valid one cycle after bram_en_o.
REQ-014 SHALL have port buf_wr_en_o  output  1  line-buffer write strobe.
REQ-015 SHALL have port buf_wr_addr_o  output  11  line-buffer write address.
REQ-016 SHALL have port buf_wdata_o  output  8  line-buffer write data.
REQ-017 SHALL have port state_o  output  3  current FSM state, debug.

Function
REQ-018 SHALL implement states S_IDLE=0, S_READ=1, S_DRAIN=2, S_DONE=3, S_WAIT=4.
REQ-019 S_IDLE: on fetch_run_i=1, latch len=min(cnt_len_i, BUF_DEPTH) and go to S_READ. If len=0, go directly to S_DONE.
REQ-020 S_READ: bram_en_o=1 each cycle, bram_addr_o=win_base+i for i=0..len-1. Go to S_DRAIN after issuing i=len-1.
REQ-021 Read-to-write latency SHALL be exactly 1 cycle: buf_wr_en_o=1, buf_wr_addr_o=i, buf_wdata_o=bram_rdata_i in the cycle after issue i.
REQ-022 S_DRAIN SHALL complete the final buffer write, then go to S_DONE.
REQ-023 S_DONE SHALL assert fetch_done_o for exactly one cycle, update cnt_img_row_o to the window's top row, then go to S_WAIT.
REQ-024 S_WAIT SHALL hold until fetch_run_i=0, then go to S_IDLE; a held-high fetch_run_i SHALL NOT retrigger a fetch.
REQ-025 Timing: fetch_run_i sampled high at edge 0 gives bram_en_o in cycles 1..len, writes in 2..len+1, and fetch_done_o in cycle len+2.
REQ-026 Window stepping: first fetch after reset uses top row 0. Each later fetch uses top row+1.
REQ-027 Wrap: after top row MAX_ROW-3 completes, the next fetch SHALL use top row 0 (new frame).
REQ-028 win_base SHALL equal top_row*MAX_COL and SHALL be produced by accumulation (+MAX_COL per step, reset to 0 on wrap), with no multiplier.
REQ-029 Addresses at or above MAX_ROW*MAX_COL SHALL NOT assert bram_en_o. The matching buffer entry SHALL be written with 0x00.
REQ-030 Abort: if fetch_run_i falls in S_READ or S_DRAIN, go to S_IDLE next cycle, with no fetch_done_o and no row advance. The next fetch SHALL reuse the same top row.
REQ-031 cnt_len_i changes after the start cycle SHALL be ignored.

Reset
REQ-032 While rst_n=0, state=S_IDLE; fetch_done_o, bram_en_o and buf_wr_en_o are 0; bram_addr_o, buf_wr_addr_o, buf_wdata_o and cnt_img_row_o are 0; top row, win_base and the first-fetch flag are cleared.
REQ-033 Reset asserted mid-transfer SHALL stop BRAM reads and buffer writes immediately, with no done pulse.

Structure
REQ-034 Package fetch_pkg SHALL hold MAX_ROW, MAX_COL, IMG_SIZE=MAX_ROW*MAX_COL, BUF_DEPTH, WIN_ROWS=3, and the 3-bit state encoding.
REQ-035 Sub-module fetch_addr_gen SHALL own top-row/win_base stepping and wrap. It takes advance/abort inputs and outputs top_row and win_base.

Verification
REQ-036 Reset, then fetch_run_i=1 with cnt_len_i=1620 and data = address LSBs -> reads at addresses 0..1619; buffer[i]=i[7:0]; done pulse in cycle 1622; cnt_img_row_o=0.
REQ-037 Second fetch with len 1620 -> addresses 540..2159; cnt_img_row_o=1.
REQ-038 Run 538 fetches -> cnt_img_row_o=537 on the last one; the 539th fetch starts at address 0 and reports row 0.
REQ-039 cnt_len_i=0 -> no bram_en_o, fetch_done_o at cycle 1; cnt_len_i=5000 -> exactly 2048 writes.
REQ-040 Drop fetch_run_i at read 700 -> no done pulse and no row advance; the retry reissues the same addresses.
REQ-041 Hold fetch_run_i high for 10 cycles after done -> state stays S_WAIT, no new reads; assert rst_n=0 mid-read -> all strobes 0 in the same cycle.
